// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor. Computes {bout,d} = a - b - bin
//                one bit per clock, LSB first, through a single one-bit
//                subtractor stage and a borrow flop. Three-state control:
//                IDLE -> SHIFT (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // Counter is wide enough to hold WIDTH itself, so it never wraps mid-op.
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_res;
    logic                 r_br;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_d;
    logic                 r_bout;

    logic                 w_accept;
    logic                 w_shift;
    logic                 w_last;
    logic                 w_diff;
    logic                 w_br_next;

    // One-bit subtractor stage operating on the current LSBs and the borrow.
    always_comb begin
        w_diff    = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    end

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs derived from the current state.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                // The edge that processes bit WIDTH-1 is the final one.
                if (r_cnt == c_last_bit) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_res <= {w_diff, r_res[WIDTH-1:1]};
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers load only on the edge that completes the operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_d    <= {w_diff, r_res[WIDTH-1:1]};
            r_bout <= w_br_next;
        end
    end

    assign d    = r_d;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port busy, output, 1 bit: a subtraction is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port d, output, WIDTH bits: registered difference.
REQ-011 The block SHALL have port bout, output, 1 bit: registered borrow-out.

Function
REQ-012 The block SHALL compute {bout,d} such that d = (a - b - bin) mod 2^WIDTH, and bout = 1 iff a < b + bin (unsigned).
REQ-013 The block SHALL process one bit per SHIFT cycle, LSB first, using a single one-bit subtractor stage:
- diff = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
REQ-014 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, and no other reachable states.
REQ-015 In IDLE, a rising edge with start=1 SHALL:
- capture a, b into shift registers;
- load the borrow flop with bin;
- clear the bit counter;
- enter SHIFT.
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-017 Each SHIFT edge SHALL:
- shift diff into the result shift register at the MSB;
- shift the operand registers right by one;
- update the borrow flop to br_next;
- increment the counter.
REQ-018 The block SHALL leave SHIFT on the edge that processes bit WIDTH-1 (the WIDTH-th SHIFT edge) and enter DONE.
- On that same edge, d SHALL load the completed result and bout SHALL load the final br_next.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly while the state is SHIFT.
REQ-021 done SHALL be 1 exactly while the state is DONE.
REQ-022 Latency SHALL be as follows, for a start accepted at edge k:
- busy is high after edges k .. k+WIDTH-1;
- done is high for the cycle following edge k+WIDTH.
REQ-023 d and bout SHALL change only on the edge entering DONE (or on reset); they SHALL hold until the next completion.
REQ-024 start SHALL be ignored in SHIFT and DONE; the operation in progress and its result SHALL be unaffected.
REQ-025 a, b and bin SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.
REQ-026 start held high continuously SHALL produce back-to-back operations, each accepted on the first IDLE edge after the previous DONE (period WIDTH+2 cycles).
REQ-027 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge:
- force the state to IDLE;
- clear the operand registers, result shift register, borrow flop and counter;
- drive busy=0, done=0, d=0, bout=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse.
- The first start accepted after rst deasserts SHALL complete normally.
REQ-030 Outputs SHALL hold their reset values while rst=1, regardless of start.

Verification (WIDTH=8)
REQ-031 The bench SHALL drive a=8'h5A, b=8'h3C, bin=0 with a start pulse and require:
- d=8'h1E, bout=0;
- done high exactly one cycle, 8 cycles after the start edge;
- busy high for 8 cycles.
REQ-032 The bench SHALL drive a=8'h00, b=8'h01, bin=0 and require d=8'hFF, bout=1.
- It SHALL also drive a=8'h80, b=8'h7F, bin=1 and require d=8'h00, bout=0.
REQ-033 The bench SHALL pulse start again and change a, b mid-operation and require:
- the result matches the originally captured operands;
- exactly one done pulse.
REQ-034 The bench SHALL assert rst during the 4th SHIFT cycle and require:
- busy, done, d and bout all 0 immediately;
- no done pulse;
- a subsequent a=8'hFF, b=8'h0F, bin=0 yields d=8'hF0, bout=0.
REQ-035 The bench SHALL hold start=1 continuously for 3 operations and require done pulses spaced 10 cycles apart with correct results.
REQ-036 The bench SHALL run 1000 random {a,b,bin} operations and require {bout,d} to match a reference computation of a - b - bin every time.
